// File: rtl/axis_to_ft245_sync_dev_pkg.sv
// rtl/axis_to_ft245_sync_dev_pkg.sv - shared types and helpers for the FT245 sync device model
package ft245_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_READ = 2'd2
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_to_ft245_sync_dev_if.sv
// rtl/axis_to_ft245_sync_dev_if.sv - AXIS-style stream bundle; tlast exists only with FT245_DEV_SIWU_EN
interface axis_to_ft245_sync_dev_if #(
  parameter int BW = 1
);
  logic [BW*8-1:0] tdata;
  logic [BW-1:0]   tkeep;
  logic            tvalid;
  logic            tready;
`ifdef FT245_DEV_SIWU_EN
  logic            tlast;
`endif

  modport master (
    input  tready,
    output tdata, tkeep, tvalid
`ifdef FT245_DEV_SIWU_EN
    , tlast
`endif
  );

  modport slave (
    output tready,
    input  tdata, tkeep, tvalid
`ifdef FT245_DEV_SIWU_EN
    , tlast
`endif
  );
endinterface

// File: rtl/axis_to_ft245_sync_dev_fifo.sv
// rtl/axis_to_ft245_sync_dev_fifo.sv - single-clock first-word-fall-through FIFO with flush
// mark_i sets the top bit of the newest stored entry (used for send-immediate tagging).
module ft245_dev_fifo
  import ft245_sync_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     mark_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [clog2(DEPTH):0]    count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end else if (mark_i && !empty_o) begin
      mem_q[wr_ptr_q - AW'(1)][WIDTH-1] <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_to_ft245_sync_dev.sv
// rtl/axis_to_ft245_sync_dev.sv - FT245 synchronous FIFO device-side emulator bridging to AXIS
// Optional send-immediate/tlast support is built with FT245_DEV_SIWU_EN.
module axis_to_ft245_sync_dev
  import ft245_sync_pkg::*;
#(
  parameter int bus_width  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int TX_MARGIN  = 2
) (
  input  logic                     ft245_dclk,
  input  logic                     rstn,
  inout  wire  [bus_width*8-1:0]   ft245_data,
  inout  wire  [bus_width-1:0]     ft245_ben,
  input  logic                     ft245_rdn,
  input  logic                     ft245_wrn,
  input  logic                     ft245_oen,
  input  logic                     ft245_siwun,
  input  logic                     ft245_rstn,
  input  logic                     ft245_wakeupn,
  output logic                     ft245_rxfn,
  output logic                     ft245_txen,
  axis_to_ft245_sync_dev_if.slave  s_axis,
  axis_to_ft245_sync_dev_if.master m_axis,
  output logic [1:0]               rx_state_o
);
  localparam int DW = bus_width * 8;
  localparam int BW = bus_width;
  localparam int CW = clog2(FIFO_DEPTH) + 1;
`ifdef FT245_DEV_SIWU_EN
  localparam int LW = 1;
`else
  localparam int LW = 0;
`endif
  localparam int RXW = DW + BW;
  localparam int TXW = DW + BW + LW;

  rx_state_e      state_q;
  logic           tready_q;
  logic           tx_drop_q;
  logic [RXW-1:0] rx_head;
  logic [TXW-1:0] tx_head, tx_push_data;
  logic [CW-1:0]  rx_cnt, tx_cnt, rx_cnt_d, tx_cnt_d;
  logic           tx_empty, tx_mark;
  logic           rx_push, rx_pop, tx_wr, tx_pop, tx_drop;
  logic           rxfn_d;
  logic           unused_rx_full, unused_rx_empty, unused_tx_full, unused_sigs;

  assign ft245_data = ft245_oen ? 'z : rx_head[DW-1:0];
  assign ft245_ben  = ft245_oen ? 'z : rx_head[RXW-1:DW];

  // Writes are only honoured while the FPGA owns the bus (oen high).
  assign rx_push = s_axis.tvalid && tready_q;
  assign rx_pop  = !ft245_rdn && !ft245_oen && !ft245_rxfn && (state_q != ST_IDLE);
  assign tx_wr   = !ft245_wrn && ft245_oen && !ft245_txen;
  assign tx_drop = !ft245_wrn && ft245_oen && ft245_txen;
  assign tx_pop  = m_axis.tvalid && m_axis.tready;

  assign rx_cnt_d = rx_cnt + CW'(rx_push) - CW'(rx_pop);
  assign tx_cnt_d = tx_cnt + CW'(tx_wr) - CW'(tx_pop);
  assign rxfn_d   = (rx_cnt_d == '0);

`ifdef FT245_DEV_SIWU_EN
  assign tx_push_data = {~ft245_siwun, ft245_ben, ft245_data};
  assign tx_mark      = !ft245_siwun;
  assign m_axis.tlast = tx_head[TXW-1];
`else
  assign tx_push_data = {ft245_ben, ft245_data};
  assign tx_mark      = 1'b0;
`endif

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = !tx_empty;
  assign m_axis.tdata  = tx_head[DW-1:0];
  assign m_axis.tkeep  = tx_head[DW+BW-1:DW];
  assign rx_state_o    = state_q;
  assign unused_sigs   = ^{ft245_wakeupn, ft245_siwun, tx_drop_q};

  always_ff @(posedge ft245_dclk) begin
    if (!rstn || !ft245_rstn) begin
      ft245_rxfn <= 1'b1;
      ft245_txen <= 1'b1;
      tready_q   <= 1'b0;
      tx_drop_q  <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      ft245_rxfn <= rxfn_d;
      tready_q   <= (rx_cnt_d != CW'(FIFO_DEPTH));
      // txen rises once only the margin words remain free.
      ft245_txen <= (tx_cnt_d >= CW'(FIFO_DEPTH - TX_MARGIN));
      if (tx_drop) tx_drop_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: if (!ft245_oen) state_q <= ST_TURN;
        ST_TURN: state_q <= ft245_oen ? ST_IDLE : ST_READ;
        ST_READ: if (ft245_oen || (rxfn_d && !ft245_rxfn)) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ft245_dev_fifo #(.WIDTH(RXW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i       (ft245_dclk),
    .rstn_i      (rstn),
    .flush_i     (!ft245_rstn),
    .push_i      (rx_push),
    .push_data_i ({s_axis.tkeep, s_axis.tdata}),
    .pop_i       (rx_pop),
    .mark_i      (1'b0),
    .head_o      (rx_head),
    .count_o     (rx_cnt),
    .full_o      (unused_rx_full),
    .empty_o     (unused_rx_empty)
  );

  ft245_dev_fifo #(.WIDTH(TXW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i       (ft245_dclk),
    .rstn_i      (rstn),
    .flush_i     (!ft245_rstn),
    .push_i      (tx_wr),
    .push_data_i (tx_push_data),
    .pop_i       (tx_pop),
    .mark_i      (tx_mark),
    .head_o      (tx_head),
    .count_o     (tx_cnt),
    .full_o      (unused_tx_full),
    .empty_o     (tx_empty)
  );

endmodule

// File: tb/tb_axis_to_ft245_sync_dev.sv
// tb/tb_axis_to_ft245_sync_dev.sv - directed self-checking bench for axis_to_ft245_sync_dev
module tb_axis_to_ft245_sync_dev;
  logic clk = 1'b0;
  logic rstn, ft245_rstn, rdn, wrn, oen, siwun, wakeupn;
  logic rxfn, txen;
  logic [7:0] tb_data;
  logic [0:0] tb_ben;
  logic [1:0] rx_state;
  wire  [7:0] ft245_data;
  wire  [0:0] ft245_ben;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ft245_data = oen ? tb_data : 'z;
  assign ft245_ben  = oen ? tb_ben  : 'z;

  axis_to_ft245_sync_dev_if #(.BW(1)) s_axis_if ();
  axis_to_ft245_sync_dev_if #(.BW(1)) m_axis_if ();

  axis_to_ft245_sync_dev #(.bus_width(1), .FIFO_DEPTH(8), .TX_MARGIN(2)) dut (
    .ft245_dclk    (clk),
    .rstn          (rstn),
    .ft245_data    (ft245_data),
    .ft245_ben     (ft245_ben),
    .ft245_rdn     (rdn),
    .ft245_wrn     (wrn),
    .ft245_oen     (oen),
    .ft245_siwun   (siwun),
    .ft245_rstn    (ft245_rstn),
    .ft245_wakeupn (wakeupn),
    .ft245_rxfn    (rxfn),
    .ft245_txen    (txen),
    .s_axis        (s_axis_if.slave),
    .m_axis        (m_axis_if.master),
    .rx_state_o    (rx_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rd_exp [3];

  initial begin
    rstn = 1'b0; ft245_rstn = 1'b1; rdn = 1'b1; wrn = 1'b1; oen = 1'b1;
    siwun = 1'b1; wakeupn = 1'b1; tb_data = 8'h00; tb_ben = 1'b1;
    s_axis_if.tvalid = 1'b0; s_axis_if.tdata = 8'h00; s_axis_if.tkeep = 1'b1;
    m_axis_if.tready = 1'b0;
    rd_exp[0] = 8'h11; rd_exp[1] = 8'h22; rd_exp[2] = 8'h33;

    // Reset
    tick(); tick();
    check("rst_rxfn", rxfn, 1);
    check("rst_txen", txen, 1);
    check("rst_tready", s_axis_if.tready, 0);
    check("rst_mvalid", m_axis_if.tvalid, 0);
    rstn = 1'b1;
    tick();
    check("rel_tready", s_axis_if.tready, 1);
    check("rel_txen", txen, 0);
    check("rel_rxfn", rxfn, 1);

    // Read burst
    s_axis_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_if.tdata = rd_exp[i];
      tick();
    end
    s_axis_if.tvalid = 1'b0;
    check("rd_rxfn_low", rxfn, 0);
    oen = 1'b0;
    #1;
    check("rd_fwft", ft245_data, 8'h11);
    check("rd_ben", ft245_ben, 1);
    tick();
    check("rd_state_turn", rx_state, 1);
    rdn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rd_data", ft245_data, rd_exp[i]);
      check("rd_rxfn_hold", rxfn, 0);
      tick();
    end
    check("rd_rxfn_empty", rxfn, 1);
    check("rd_state_idle", rx_state, 0);
    rdn = 1'b1; oen = 1'b1;
    tick();

    // Write burst until txen, then one dropped write
    check("wr_drop_clear", dut.tx_drop_q, 0);
    wrn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("wr_txen_low", txen, 0);
      tb_data = 8'hA0 + 8'(i);
      tick();
    end
    check("wr_txen_high", txen, 1);
    tb_data = 8'hEE;
    tick();
    wrn = 1'b1;
    check("wr_drop_set", dut.tx_drop_q, 1);
    check("wr_mvalid", m_axis_if.tvalid, 1);
    m_axis_if.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("drain_data", m_axis_if.tdata, 8'hA0 + 8'(i));
      tick();
    end
    check("drain_empty", m_axis_if.tvalid, 0);
    check("drain_txen", txen, 0);
    m_axis_if.tready = 1'b0;

    // Same-edge push/pop at count 1
    s_axis_if.tvalid = 1'b1; s_axis_if.tdata = 8'h55;
    tick();
    s_axis_if.tvalid = 1'b0;
    oen = 1'b0;
    tick();
    rdn = 1'b0; s_axis_if.tvalid = 1'b1; s_axis_if.tdata = 8'h66;
    check("pp_head", ft245_data, 8'h55);
    tick();
    s_axis_if.tvalid = 1'b0;
    check("pp_rxfn", rxfn, 0);
    check("pp_next", ft245_data, 8'h66);
    tick();
    check("pp_empty", rxfn, 1);
    rdn = 1'b1;

    // Contention: write while device drives the bus
    wrn = 1'b0;
    tick();
    wrn = 1'b1;
    check("cont_mvalid", m_axis_if.tvalid, 0);
    oen = 1'b1;
    tick();

    // ft245_rstn flush with 2 RX + 2 TX words queued
    s_axis_if.tvalid = 1'b1; wrn = 1'b0;
    s_axis_if.tdata = 8'h77; tb_data = 8'hB1;
    tick();
    s_axis_if.tdata = 8'h78; tb_data = 8'hB2;
    tick();
    s_axis_if.tvalid = 1'b0; wrn = 1'b1;
    check("fl_pre_rxfn", rxfn, 0);
    check("fl_pre_mvalid", m_axis_if.tvalid, 1);
    ft245_rstn = 1'b0;
    tick();
    ft245_rstn = 1'b1;
    check("fl_rxfn", rxfn, 1);
    check("fl_mvalid", m_axis_if.tvalid, 0);
    check("fl_tready", s_axis_if.tready, 0);
    check("fl_txen", txen, 1);
    tick();
    check("fl_rel_tready", s_axis_if.tready, 1);
    check("fl_rel_txen", txen, 0);
    s_axis_if.tvalid = 1'b1; s_axis_if.tdata = 8'h99;
    tick();
    s_axis_if.tvalid = 1'b0;
    oen = 1'b0;
    #1;
    check("fl_fresh_head", ft245_data, 8'h99);
    oen = 1'b1;
    tick();

`ifdef FT245_DEV_SIWU_EN
    // Send-immediate tagging
    wrn = 1'b0; tb_data = 8'h01;
    tick();
    tb_data = 8'h02; siwun = 1'b0;
    tick();
    siwun = 1'b1; tb_data = 8'h03;
    tick();
    wrn = 1'b1; siwun = 1'b0;
    tick();
    siwun = 1'b1;
    m_axis_if.tready = 1'b1;
    check("siwu_d0", m_axis_if.tdata, 8'h01);
    check("siwu_l0", m_axis_if.tlast, 0);
    tick();
    check("siwu_d1", m_axis_if.tdata, 8'h02);
    check("siwu_l1", m_axis_if.tlast, 1);
    tick();
    check("siwu_d2", m_axis_if.tdata, 8'h03);
    check("siwu_l2", m_axis_if.tlast, 1);
    tick();
    check("siwu_empty", m_axis_if.tvalid, 0);
    m_axis_if.tready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
